// File: rtl/net_packet_trace_buffer.sv
// ---------------------------------------------------------------------------
// net_packet_trace_buffer
//
// Purpose:
//   Snoops up to channels_p net_packet_s streams and records at most one
//   packet per cycle into a small circular trace memory. Each entry is
//   {channel index, cycle stamp, packet}. A round-robin arbiter picks
//   one channel when several want to be captured. The losers, and any packet
//   refused by a full buffer in stop mode, are counted as drops. Reads are
//   show-ahead: entry_o always presents the oldest entry.
//
// Ports:
//   clk             single clock, rising edge
//   n_reset         asynchronous active-low reset
//   net_packet_i    one monitored packet per channel per cycle
//   cycle_counter_i timestamp sampled with the captured packet
//   cap_en_i        capture enables {PC, BAR, REG, INSTR}
//   mode_i          0 = overwrite oldest when full, 1 = stop when full
//   freeze_i        blocks all capture (reads unaffected)
//   rd_en_i         pop the oldest entry
//   entry_o         oldest entry, zero when empty
//   entry_valid_o   buffer non-empty
//   count_o         number of entries held
//   full_o          count_o == depth_p
//   drop_count_o    saturating count of lost packets
//   wrapped_o       sticky: an entry has been overwritten
// ---------------------------------------------------------------------------

package net_packet_trace_pkg;

    localparam logic [2:0] NET_OP_NULL  = 3'd0;
    localparam logic [2:0] NET_OP_INSTR = 3'd1;
    localparam logic [2:0] NET_OP_REG   = 3'd2;
    localparam logic [2:0] NET_OP_BAR   = 3'd3;
    localparam logic [2:0] NET_OP_PC    = 3'd4;

    typedef struct packed {
        logic [2:0]  net_op;
        logic [15:0] payload;
    } net_packet_s;

endpackage

module net_packet_trace_buffer
    import net_packet_trace_pkg::*;
#(
    parameter int  channels_p = 2,
    parameter int  depth_p    = 16,
    localparam int chan_w     = (channels_p > 1) ? $clog2(channels_p) : 1,
    localparam int ptr_w      = $clog2(depth_p),
    localparam int cnt_w      = ptr_w + 1,
    localparam int pkt_w      = $bits(net_packet_s),
    localparam int entry_w    = chan_w + 32 + pkt_w
)(
    input  logic                         clk,
    input  logic                         n_reset,
    input  net_packet_s [channels_p-1:0] net_packet_i,
    input  logic [31:0]                  cycle_counter_i,
    input  logic [3:0]                   cap_en_i,
    input  logic                         mode_i,
    input  logic                         freeze_i,
    input  logic                         rd_en_i,
    output logic [entry_w-1:0]           entry_o,
    output logic                         entry_valid_o,
    output logic [cnt_w-1:0]             count_o,
    output logic                         full_o,
    output logic [15:0]                  drop_count_o,
    output logic                         wrapped_o
);

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [entry_w-1:0] r_mem [depth_p];
    logic [ptr_w-1:0]   r_wr_ptr;
    logic [ptr_w-1:0]   r_rd_ptr;
    logic [chan_w-1:0]  r_rr_ptr;
    logic [cnt_w-1:0]   r_count;
    logic [15:0]        r_drop_count;
    logic               r_wrapped;

    // -----------------------------------------------------------------------
    // Combinational signals
    // -----------------------------------------------------------------------
    logic [channels_p-1:0] w_cand;
    logic [3:0]            w_num_cand;
    logic                  w_grant_vld;
    logic [chan_w-1:0]     w_grant_idx;
    net_packet_s           w_grant_pkt;
    logic [entry_w-1:0]    w_wr_data;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_pop;
    logic                  w_write;
    logic                  w_overwrite;
    logic                  w_discard;

    logic [cnt_w-1:0]      w_count_next;
    logic [chan_w-1:0]     w_rr_next;
    logic [4:0]            w_drop_inc;
    logic [16:0]           w_drop_sum;
    logic [15:0]           w_drop_next;

    // -----------------------------------------------------------------------
    // Candidate decode. Ops outside the four known kinds have no enable bit
    // and are always captured so that unexpected traffic is never hidden.
    // -----------------------------------------------------------------------
    always_comb begin
        w_cand = '0;
        if (!freeze_i) begin
            for (int c = 0; c < channels_p; c++) begin
                case (net_packet_i[c].net_op)
                    NET_OP_NULL:  w_cand[c] = 1'b0;
                    NET_OP_INSTR: w_cand[c] = cap_en_i[0];
                    NET_OP_REG:   w_cand[c] = cap_en_i[1];
                    NET_OP_BAR:   w_cand[c] = cap_en_i[2];
                    NET_OP_PC:    w_cand[c] = cap_en_i[3];
                    default:      w_cand[c] = 1'b1;
                endcase
            end
        end
    end

    always_comb begin
        w_num_cand = '0;
        for (int c = 0; c < channels_p; c++) begin
            w_num_cand = w_num_cand + {3'b000, w_cand[c]};
        end
    end

    // -----------------------------------------------------------------------
    // Round-robin arbiter: first pass looks at indices at or above the
    // pointer, second pass wraps around to the low indices.
    // -----------------------------------------------------------------------
    always_comb begin
        w_grant_vld = 1'b0;
        w_grant_idx = '0;
        for (int c = 0; c < channels_p; c++) begin
            if (!w_grant_vld && w_cand[c] && (c >= int'(r_rr_ptr))) begin
                w_grant_vld = 1'b1;
                w_grant_idx = chan_w'(c);
            end
        end
        for (int c = 0; c < channels_p; c++) begin
            if (!w_grant_vld && w_cand[c]) begin
                w_grant_vld = 1'b1;
                w_grant_idx = chan_w'(c);
            end
        end
    end

    always_comb begin
        w_grant_pkt = '0;
        for (int c = 0; c < channels_p; c++) begin
            if (chan_w'(c) == w_grant_idx) begin
                w_grant_pkt = net_packet_i[c];
            end
        end
    end

    assign w_wr_data = {w_grant_idx, cycle_counter_i, w_grant_pkt};

    always_comb begin
        w_rr_next = r_rr_ptr;
        if (w_grant_vld) begin
            if (w_grant_idx == chan_w'(channels_p - 1)) begin
                w_rr_next = '0;
            end else begin
                w_rr_next = w_grant_idx + chan_w'(1);
            end
        end
    end

    // -----------------------------------------------------------------------
    // Buffer control. When full, wr_ptr == rd_ptr, so a write that coincides
    // with a pop lands on the slot being popped and needs no special case.
    // -----------------------------------------------------------------------
    assign w_full      = (r_count == cnt_w'(depth_p));
    assign w_empty     = (r_count == '0);
    assign w_pop       = rd_en_i && !w_empty;
    assign w_overwrite = w_grant_vld && w_full && !w_pop && !mode_i;
    assign w_discard   = w_grant_vld && w_full && !w_pop &&  mode_i;
    assign w_write     = w_grant_vld && !w_discard;

    always_comb begin
        w_count_next = r_count;
        if (w_write && !w_pop && !w_full) begin
            w_count_next = r_count + cnt_w'(1);
        end else if (w_pop && !w_write) begin
            w_count_next = r_count - cnt_w'(1);
        end
    end

    // Losing candidates plus a refused grant; a grant implies at least one
    // candidate so the subtraction never goes negative.
    assign w_drop_inc  = {1'b0, w_num_cand} - {4'b0000, w_grant_vld}
                       + {4'b0000, w_discard};
    assign w_drop_sum  = {1'b0, r_drop_count} + {12'h000, w_drop_inc};
    assign w_drop_next = w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];

    // -----------------------------------------------------------------------
    // Sequential state
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_rr_ptr     <= '0;
            r_count      <= '0;
            r_drop_count <= '0;
            r_wrapped    <= 1'b0;
        end else begin
            if (w_write) begin
                r_wr_ptr <= r_wr_ptr + ptr_w'(1);
            end
            if (w_pop || w_overwrite) begin
                r_rd_ptr <= r_rd_ptr + ptr_w'(1);
            end
            if (w_overwrite) begin
                r_wrapped <= 1'b1;
            end
            r_rr_ptr     <= w_rr_next;
            r_count      <= w_count_next;
            r_drop_count <= w_drop_next;
        end
    end

    // Storage is not reset; the guard keeps an edge that arrives while reset
    // is held from leaving a stray write behind.
    always_ff @(posedge clk) begin
        if (n_reset && w_write) begin
            r_mem[r_wr_ptr] <= w_wr_data;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign entry_o       = w_empty ? '0 : r_mem[r_rd_ptr];
    assign entry_valid_o = !w_empty;
    assign count_o       = r_count;
    assign full_o        = w_full;
    assign drop_count_o  = r_drop_count;
    assign wrapped_o     = r_wrapped;

endmodule

// File: doc/net_packet_trace_buffer.md
NET_PACKET_TRACE_BUFFER -- requirements
Module: net_packet_trace_buffer

Interface
REQ-001 SHALL have parameter channels_p, default 2: number of monitored net_packet_s channels, range 1..8.
REQ-002 SHALL have parameter depth_p, default 16: trace entries stored, power of two, at least 2.
REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on posedge.
REQ-004 SHALL have port n_reset, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port net_packet_i, input, channels_p x net_packet_s: monitored packets, one per channel per cycle.
REQ-006 SHALL have port cycle_counter_i, input, 32: timestamp source.
REQ-007 SHALL have port cap_en_i, input, 4: per-op capture enable; bit0 INSTR, bit1 REG, bit2 BAR, bit3 PC.
REQ-008 SHALL have port mode_i, input, 1: 0 = wrap (overwrite oldest), 1 = stop when full.
REQ-009 SHALL have port freeze_i, input, 1: 1 blocks all capture.
REQ-010 SHALL have port rd_en_i, input, 1: pop the oldest entry.
REQ-011 SHALL have port entry_o, output, chan_w+32+$bits(net_packet_s): oldest entry {channel index, stamp, packet}, with chan_w = max(1, clog2(channels_p)).
REQ-012 SHALL have port entry_valid_o, output, 1: buffer non-empty.
REQ-013 SHALL have port count_o, output, clog2(depth_p)+1: entries held.
REQ-014 SHALL have port full_o, output, 1: count_o == depth_p.
REQ-015 SHALL have port drop_count_o, output, 16: saturating count of lost packets.
REQ-016 SHALL have port wrapped_o, output, 1: sticky flag, set when any entry was overwritten.

Function
REQ-017 Channel c SHALL be a candidate in a cycle when:
- net_op != NULL, and
- freeze_i == 0, and
- either its op's cap_en_i bit is 1, or its op is not INSTR/REG/BAR/PC (unknown ops always captured).
REQ-018 Grant SHALL be round-robin: the lowest candidate index >= rr_ptr, wrapping to 0; after a grant, rr_ptr <= (granted+1) mod channels_p; rr_ptr SHALL be unchanged when there is no grant.
REQ-019 The granted packet SHALL be written at wr_ptr on the clock edge as {granted index, cycle_counter_i, packet}, all sampled in the grant cycle.
REQ-020 A written entry SHALL be visible on entry_o no earlier than the cycle after the write; there is no same-cycle bypass.
REQ-021 entry_o SHALL show the oldest entry (show-ahead) while count_o > 0, and SHALL be all zeros when empty.
REQ-022 rd_en_i with count_o > 0 SHALL advance rd_ptr on the edge; rd_en_i when empty SHALL be ignored.
REQ-023 A write without a pop SHALL increment count_o; a pop without a write SHALL decrement it; a simultaneous write and pop SHALL leave it unchanged.
REQ-024 When full, mode_i=0, write, no pop: SHALL overwrite the oldest entry, advance rd_ptr and wr_ptr, leave count_o unchanged, and set wrapped_o.
REQ-025 When full, mode_i=1, no pop: SHALL discard the granted packet and count it as a drop.
REQ-026 When full with a simultaneous pop (either mode): the write SHALL proceed, count_o SHALL be unchanged, and wrapped_o SHALL NOT be set.
REQ-027 Each cycle, drop_count_o SHALL add (non-granted candidates + discarded grant), saturating at 0xFFFF.
REQ-028 wr_ptr and rd_ptr SHALL wrap modulo depth_p.
REQ-029 freeze_i SHALL NOT affect reads; mode_i changes SHALL take effect on the next edge.

Reset
REQ-030 While n_reset is low, the block SHALL asynchronously clear to:
- wr_ptr, rd_ptr, rr_ptr, count_o, drop_count_o = 0
- wrapped_o, entry_valid_o, full_o = 0
- entry_o = 0
REQ-031 Storage array contents need not be reset.
REQ-032 Capture SHALL begin on the first posedge after n_reset deasserts.
REQ-033 Reset asserted mid-operation SHALL discard all entries, with no partial write.

Verification
REQ-034 Reset, then a single REG packet on ch0 at cycle 0x10 -> next cycle entry_valid_o=1, count_o=1, entry_o={0,0x00000010,pkt}; rd_en_i -> count_o=0, entry_o=0.
REQ-035 channels_p=2, both channels send PC packets for 4 cycles, rr_ptr=0 -> grants 0,1,0,1; drop_count_o=4; the four entries read back in that order.
REQ-036 depth_p=4, mode_i=0, 6 single packets A..F, no reads -> count_o=4, wrapped_o=1, reads return C,D,E,F.
REQ-037 depth_p=4, mode_i=1, 6 packets A..F -> reads return A..D, drop_count_o=2, wrapped_o=0; full + write + pop in the same cycle -> count_o stays 4.
REQ-038 cap_en_i=4'b0100 with INSTR/BAR/NULL mix -> only BAR captured; freeze_i=1 -> nothing captured, drop_count_o unchanged, reads still pop.
REQ-039 Force 70000 contended drops -> drop_count_o=0xFFFF; n_reset pulse low mid-burst -> all outputs 0 immediately, without waiting for a clock edge.
